// File: rtl/cirno_regfile_pkg.sv
// cirno_regfile_pkg: op codes and FSM states shared by the Cirno register file.
package cirno_regfile_pkg;
  typedef enum logic [2:0] {
    NOP     = 3'd0,
    READ    = 3'd1,
    WRITE   = 3'd2,
    LOAD_HI = 3'd3,
    LOAD_LO = 3'd4,
    COPY    = 3'd5,
    SWAP    = 3'd6
  } regfile_op_t;
  typedef enum logic {IDLE, SWAP2} regfile_state_t;
endpackage

// File: rtl/cirno_regfile.sv
// cirno_regfile: DEPTH x WIDTH register file, registered dual read, single write port, two-cycle swap.
// Define CIRNO_REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module cirno_regfile
  import cirno_regfile_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  regfile_op_t        op,
  input  logic [AW-1:0]      ra,
  input  logic [AW-1:0]      rb,
  input  logic               rd_x_en,
  input  logic               rd_y_en,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/2-1:0] imm,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  output logic               rd_valid
);
`ifdef CIRNO_REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] x_q, y_q, tmp_q, rx, ry, wd;
  logic [AW-1:0]    ra_lat_q, wa;
  logic             rd_valid_q, accept, we;
  regfile_state_t   state_q, state_d;
  assign op_ready = (state_q == IDLE) && !rst;
  assign accept   = op_valid && op_ready;
  assign rx       = (ZR && ra == '0) ? '0 : mem_q[ra];
  assign ry       = (ZR && rb == '0) ? '0 : mem_q[rb];
  assign state_d  = (state_q == SWAP2) ? IDLE : (accept && op == SWAP) ? SWAP2 : IDLE;
  assign x        = x_q;
  assign y        = y_q;
  assign rd_valid = rd_valid_q;
  // The single write port is shared: SWAP2 owns it for the deferred half of a swap.
  always_comb begin
    we = 1'b0;
    wa = ra;
    wd = wdata;
    if (state_q == SWAP2) begin
      we = 1'b1;
      wa = ra_lat_q;
      wd = tmp_q;
    end else if (accept) begin
      case (op)
        WRITE:   we = 1'b1;
        LOAD_HI: begin we = 1'b1; wd = {imm, mem_q[ra][WIDTH/2-1:0]}; end
        LOAD_LO: begin we = 1'b1; wd = {mem_q[ra][WIDTH-1:WIDTH/2], imm}; end
        COPY:    begin we = 1'b1; wd = ry; end
        SWAP:    begin we = 1'b1; wa = rb; wd = rx; end
        default: ;
      endcase
    end
    if (ZR && wa == '0) we = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      x_q        <= '0;
      y_q        <= '0;
      tmp_q      <= '0;
      ra_lat_q   <= '0;
      rd_valid_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      if (we) mem_q[wa] <= wd;
      rd_valid_q <= accept && op == READ;
      if (accept && op == READ && rd_x_en) x_q <= rx;
      if (accept && op == READ && rd_y_en) y_q <= ry;
      if (accept && op == SWAP) begin
        tmp_q    <= ry;
        ra_lat_q <= ra;
      end
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_cirno_regfile.sv
// tb_cirno_regfile: directed self-checking bench for cirno_regfile (WIDTH=8, DEPTH=4).
module tb_cirno_regfile;
  import cirno_regfile_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  regfile_op_t op = NOP;
  logic [1:0]  ra = '0, rb = '0;
  logic        rd_x_en = 1'b0, rd_y_en = 1'b0;
  logic [7:0]  wdata = '0;
  logic [3:0]  imm = '0;
  logic [7:0]  x, y;
  logic        rd_valid;
  int          checks = 0;
  int          fails = 0;

  cirno_regfile dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .ra(ra), .rb(rb), .rd_x_en(rd_x_en), .rd_y_en(rd_y_en), .wdata(wdata),
    .imm(imm), .x(x), .y(y), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic do_op(input regfile_op_t o, input logic [1:0] a, input logic [1:0] b,
                       input logic xe, input logic ye, input logic [7:0] wd, input logic [3:0] im);
    op = o; ra = a; rb = b; rd_x_en = xe; rd_y_en = ye; wdata = wd; imm = im;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op = NOP;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (op_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", op_ready); end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    checks++; if (x !== 8'h00 || y !== 8'h00) begin fails++; $display("FAIL rst_xy: got %h/%h want 00/00", x, y); end
    rst = 1'b0;
    #1;
    checks++; if (op_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", op_ready); end
    for (int i = 0; i < 4; i++) begin
      do_op(READ, 2'(i), 2'(i), 1'b1, 1'b1, 8'h00, 4'h0);
      checks++; if (x !== 8'h00 || y !== 8'h00) begin fails++; $display("FAIL rst_read%0d: got %h/%h want 00/00", i, x, y); end
      checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL rst_rdv%0d: got %b want 1", i, rd_valid); end
      @(posedge clk); #1;
      checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rdv_pulse%0d: got %b want 0", i, rd_valid); end
    end
  endtask

  task automatic test_write_read();
    do_op(WRITE, 2'd2, 2'd0, 1'b0, 1'b0, 8'hA5, 4'h0);
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL wr_no_rdv: got %b want 0", rd_valid); end
    do_op(READ, 2'd2, 2'd2, 1'b1, 1'b1, 8'h00, 4'h0);
    checks++; if (x !== 8'hA5 || y !== 8'hA5) begin fails++; $display("FAIL wr_read: got %h/%h want a5/a5", x, y); end
  endtask

  task automatic test_load();
    do_op(LOAD_HI, 2'd1, 2'd0, 1'b0, 1'b0, 8'hFF, 4'h3);
    do_op(LOAD_LO, 2'd1, 2'd0, 1'b0, 1'b0, 8'hFF, 4'hC);
    do_op(READ, 2'd1, 2'd1, 1'b1, 1'b0, 8'h00, 4'h0);
    checks++; if (x !== 8'h3C) begin fails++; $display("FAIL load_3c: got %h want 3c", x); end
    do_op(LOAD_LO, 2'd1, 2'd0, 1'b0, 1'b0, 8'hFF, 4'h0);
    do_op(READ, 2'd1, 2'd1, 1'b1, 1'b0, 8'h00, 4'h0);
    checks++; if (x !== 8'h30) begin fails++; $display("FAIL load_30: got %h want 30", x); end
    do_op(LOAD_HI, 2'd1, 2'd0, 1'b0, 1'b0, 8'hFF, 4'h9);
    do_op(READ, 2'd1, 2'd1, 1'b1, 1'b0, 8'h00, 4'h0);
    checks++; if (x !== 8'h90) begin fails++; $display("FAIL load_90: got %h want 90", x); end
  endtask

  task automatic test_swap();
    logic [7:0] e0, e3;
`ifdef CIRNO_REGFILE_ZERO_REG_EN
    e0 = 8'h00; e3 = 8'h00;
`else
    e0 = 8'h22; e3 = 8'h11;
`endif
    do_op(WRITE, 2'd0, 2'd0, 1'b0, 1'b0, 8'h11, 4'h0);
    do_op(WRITE, 2'd3, 2'd0, 1'b0, 1'b0, 8'h22, 4'h0);
    op = SWAP; ra = 2'd0; rb = 2'd3; op_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (op_ready !== 1'b0) begin fails++; $display("FAIL swap_busy: got %b want 0", op_ready); end
    op = READ; ra = 2'd0; rb = 2'd3; rd_x_en = 1'b1; rd_y_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (op_ready !== 1'b1) begin fails++; $display("FAIL swap_ready_back: got %b want 1", op_ready); end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL swap_held_read: got %b want 0", rd_valid); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = NOP;
    checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL swap_read_rdv: got %b want 1", rd_valid); end
    checks++; if (x !== e0 || y !== e3) begin fails++; $display("FAIL swap_result: got %h/%h want %h/%h", x, y, e0, e3); end
    do_op(WRITE, 2'd1, 2'd0, 1'b0, 1'b0, 8'h4D, 4'h0);
    do_op(SWAP, 2'd1, 2'd1, 1'b0, 1'b0, 8'h00, 4'h0);
    checks++; if (op_ready !== 1'b0) begin fails++; $display("FAIL swap_same_busy: got %b want 0", op_ready); end
    @(posedge clk); #1;
    do_op(READ, 2'd1, 2'd1, 1'b1, 1'b1, 8'h00, 4'h0);
    checks++; if (x !== 8'h4D) begin fails++; $display("FAIL swap_same: got %h want 4d", x); end
  endtask

  task automatic test_swap_reset();
    do_op(WRITE, 2'd1, 2'd0, 1'b0, 1'b0, 8'h77, 4'h0);
    do_op(WRITE, 2'd2, 2'd0, 1'b0, 1'b0, 8'h88, 4'h0);
    do_op(SWAP, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00, 4'h0);
    checks++; if (op_ready !== 1'b0) begin fails++; $display("FAIL swrst_busy: got %b want 0", op_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (op_ready !== 1'b0) begin fails++; $display("FAIL swrst_in_rst: got %b want 0", op_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (op_ready !== 1'b1) begin fails++; $display("FAIL swrst_ready: got %b want 1", op_ready); end
    for (int i = 0; i < 4; i++) begin
      do_op(READ, 2'(i), 2'(3 - i), 1'b1, 1'b1, 8'h00, 4'h0);
      checks++; if (x !== 8'h00 || y !== 8'h00) begin fails++; $display("FAIL swrst_read%0d: got %h/%h want 00/00", i, x, y); end
    end
  endtask

  task automatic test_partial_read();
    do_op(WRITE, 2'd1, 2'd0, 1'b0, 1'b0, 8'h55, 4'h0);
    do_op(WRITE, 2'd2, 2'd0, 1'b0, 1'b0, 8'h66, 4'h0);
    do_op(WRITE, 2'd3, 2'd0, 1'b0, 1'b0, 8'h9A, 4'h0);
    do_op(READ, 2'd2, 2'd1, 1'b1, 1'b1, 8'h00, 4'h0);
    checks++; if (x !== 8'h66 || y !== 8'h55) begin fails++; $display("FAIL pr_both: got %h/%h want 66/55", x, y); end
    do_op(READ, 2'd3, 2'd2, 1'b1, 1'b0, 8'h00, 4'h0);
    checks++; if (x !== 8'h9A || y !== 8'h55) begin fails++; $display("FAIL pr_x_only: got %h/%h want 9a/55", x, y); end
    do_op(READ, 2'd1, 2'd3, 1'b0, 1'b1, 8'h00, 4'h0);
    checks++; if (x !== 8'h9A || y !== 8'h9A) begin fails++; $display("FAIL pr_y_only: got %h/%h want 9a/9a", x, y); end
    do_op(READ, 2'd2, 2'd2, 1'b0, 1'b0, 8'h00, 4'h0);
    checks++; if (rd_valid !== 1'b1 || x !== 8'h9A || y !== 8'h9A) begin fails++; $display("FAIL pr_none: got %b %h/%h want 1 9a/9a", rd_valid, x, y); end
  endtask

  task automatic test_back_to_back();
    do_op(WRITE, 2'd2, 2'd0, 1'b0, 1'b0, 8'h5A, 4'h0);
    do_op(READ, 2'd2, 2'd2, 1'b1, 1'b0, 8'h00, 4'h0);
    checks++; if (x !== 8'h5A) begin fails++; $display("FAIL b2b_raw: got %h want 5a", x); end
    do_op(COPY, 2'd3, 2'd2, 1'b0, 1'b0, 8'hEE, 4'h0);
    do_op(WRITE, 2'd2, 2'd0, 1'b0, 1'b0, 8'hC3, 4'h0);
    do_op(READ, 2'd3, 2'd2, 1'b1, 1'b1, 8'h00, 4'h0);
    checks++; if (x !== 8'h5A || y !== 8'hC3) begin fails++; $display("FAIL b2b_copy: got %h/%h want 5a/c3", x, y); end
    do_op(regfile_op_t'(3'd7), 2'd2, 2'd0, 1'b1, 1'b1, 8'h01, 4'hF);
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_op7_rdv: got %b want 0", rd_valid); end
    do_op(NOP, 2'd2, 2'd0, 1'b1, 1'b1, 8'h02, 4'hF);
    do_op(READ, 2'd2, 2'd3, 1'b1, 1'b1, 8'h00, 4'h0);
    checks++; if (x !== 8'hC3 || y !== 8'h5A) begin fails++; $display("FAIL b2b_nop: got %h/%h want c3/5a", x, y); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_load();
    test_swap();
    test_swap_reset();
    test_partial_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cirno_regfile.md
# cirno_regfile

Parametrised general-purpose register file for the Cirno core, the successor to the fixed 4×8-bit file. It holds DEPTH registers of WIDTH bits and supports registered dual reads, full writes, half-word immediate loads, copy, and a true two-cycle swap. All operations pass through a single valid/ready op port. The block sits between the decode/control stage, which issues ops, and the ALU, which consumes x/y and produces write data.

## Interface
Parameters:
- WIDTH, default 8: register width in bits; must be even and at least 2.
- DEPTH, default 4: number of registers; must be a power of 2 and at least 2.
- AW, default $clog2(DEPTH): register address width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- op_valid  in  1  op present this cycle.
- op_ready  out  1  block can accept an op this cycle.
- op  in  3  regfile_op_t: NOP, READ, WRITE, LOAD_HI, LOAD_LO, COPY, SWAP.
- ra  in  AW  primary register address; destination for all writes.
- rb  in  AW  secondary register address.
- rd_x_en  in  1  READ updates x.
- rd_y_en  in  1  READ updates y.
- wdata  in  WIDTH  write data for WRITE.
- imm  in  WIDTH/2  immediate half-word for LOAD_HI and LOAD_LO.
- x  out  WIDTH  read result for port x, addressed by ra.
- y  out  WIDTH  read result for port y, addressed by rb.
- rd_valid  out  1  one-cycle pulse: x/y were updated by a READ.

## Operation
- An op is accepted on a cycle where op_valid and op_ready are both 1.
  - If op_valid is 1 while op_ready is 0, the op is not accepted. The issuer holds op and operands until accepted.
- READ:
  - rd_x_en=1 loads x with mem[ra]; rd_y_en=1 loads y with mem[rb].
  - A disabled port holds its value.
  - rd_valid pulses even when both enables are 0.
- WRITE: mem[ra] gets wdata.
- LOAD_HI: mem[ra][WIDTH-1:WIDTH/2] gets imm; the low half is unchanged.
- LOAD_LO: mem[ra][WIDTH/2-1:0] gets imm; the high half is unchanged.
- COPY: mem[ra] gets mem[rb], using the value before the edge.
- SWAP: exchanges mem[ra] and mem[rb] using a single write port per cycle.
  - State machine states: IDLE, SWAP2.
  - IDLE, SWAP accepted: tmp gets mem[rb], mem[rb] gets mem[ra], ra is latched, next state is SWAP2.
  - SWAP2: mem[latched ra] gets tmp; op_ready=0; next state is IDLE.
  - ra==rb: contents unchanged, still takes 2 cycles.
- NOP: no state change.
- Only one op executes per cycle, so there is no read/write hazard. A READ issued the cycle after a write sees the written value.

## Timing
- Read latency is 1 cycle: x/y and rd_valid are valid in the cycle after acceptance.
- WRITE, LOAD_HI, LOAD_LO and COPY have 1-cycle latency and full throughput.
- SWAP occupies 2 cycles; op_ready is 0 during SWAP2.
- op_ready = (state==IDLE) && !rst.
- Reset values: all mem entries 0, x=0, y=0, rd_valid=0, state=IDLE, tmp=0.
- rst asserted during SWAP2 aborts the swap. After reset, all registers read 0 and no partial write of tmp occurs.
- rst takes priority over any op presented in the same cycle; that op is not executed.

## Configuration
- Macro: CIRNO_REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero.
  - WRITE, LOAD_HI, LOAD_LO and COPY targeting ra=0 are dropped.
  - SWAP with either address 0 writes nothing to register 0; the other register receives 0.
  - Reads of register 0 return 0.
- Undefined: register 0 behaves like every other register.

## Structure
- Package cirno_regfile_pkg:
  - regfile_op_t enum (3 bits): NOP=0, READ=1, WRITE=2, LOAD_HI=3, LOAD_LO=4, COPY=5, SWAP=6; value 7 is treated as NOP.
  - regfile_state_t enum: IDLE, SWAP2.
- Single module with no sub-modules. The storage array, tmp register and FSM are all in cirno_regfile.

## Test plan
- Reset then READ of every register with both enables set -> x=y=0 and rd_valid=1 for one cycle each.
- WRITE ra=2 wdata=0xA5, then READ ra=2 rb=2 -> x=y=0xA5 the cycle after the READ.
- LOAD_HI ra=1 imm=0x3, then LOAD_LO ra=1 imm=0xC, then READ -> x=0x3C; a second LOAD_LO imm=0x0 -> x=0x30.
- mem[0]=0x11, mem[3]=0x22, SWAP ra=0 rb=3 with op_valid held for the next op -> op_ready=0 for one cycle, then mem[0]=0x22 and mem[3]=0x11; with CIRNO_REGFILE_ZERO_REG_EN -> mem[0] reads 0, mem[3]=0.
- SWAP accepted, rst asserted in SWAP2 -> all registers read 0, op_ready=1 the cycle after rst deasserts.
- READ with rd_x_en=1, rd_y_en=0 after y=0x55 -> y stays 0x55 and x updates.
